// File: rtl/fifo_arb_pkg.sv
// Shared encodings for the two-port FIFO arbiter: FSM states, owner ids, counter width.
package fifo_arb_pkg;

    localparam int unsigned RETRY_W = 4;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StCheck   = 3'd2,
        StLat     = 3'd3,
        StDone    = 3'd4,
        StRecover = 3'd5
    } arb_state_e;

endpackage

// File: rtl/fifo_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: on contention the requester not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant       = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Shares one byte FIFO between requesters A and B with single-cycle do_read/do_write
// strobes, bounded retries on full/empty, and read-data capture after the bram latency.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_write,
    input  logic [7:0] a_wdata,
    output logic       a_done,
    output logic       a_err,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_write,
    input  logic [7:0] b_wdata,
    output logic       b_done,
    output logic       b_err,
    output logic [7:0] b_rdata,
    output logic       fifo_do_read,
    output logic       fifo_do_write,
    output logic [7:0] fifo_di,
    input  logic [7:0] fifo_do,
    input  logic       fifo_write_ack,
    input  logic       fifo_read_ack,
    input  logic       fifo_busy
);

    localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 1);
    localparam logic [RETRY_W-1:0] LAT_LAST = RETRY_W'(READ_LAT - 1);

    arb_state_e         state;
    logic               owner;
    logic               op_write;
    logic [7:0]         wdata;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] lat_cnt;
    logic               rr_last;
    logic               grant;
    logic               grant_valid;
    logic               ack;

    rr_arbiter2 u_rr (
        .req         ({b_req, a_req}),
        .last        (rr_last),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        ack = op_write ? fifo_write_ack : fifo_read_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StIdle;
            owner         <= OWN_A;
            op_write      <= 1'b0;
            wdata         <= 8'h00;
            retry_cnt     <= '0;
            lat_cnt       <= '0;
            rr_last       <= OWN_B;
            a_done        <= 1'b0;
            a_err         <= 1'b0;
            a_rdata       <= 8'h00;
            b_done        <= 1'b0;
            b_err         <= 1'b0;
            b_rdata       <= 8'h00;
            fifo_do_read  <= 1'b0;
            fifo_do_write <= 1'b0;
            fifo_di       <= 8'h00;
        end else begin
            a_done        <= 1'b0;
            a_err         <= 1'b0;
            b_done        <= 1'b0;
            b_err         <= 1'b0;
            fifo_do_read  <= 1'b0;
            fifo_do_write <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_valid) begin
                        owner     <= grant;
                        op_write  <= (grant == OWN_A) ? a_write : b_write;
                        wdata     <= (grant == OWN_A) ? a_wdata : b_wdata;
                        retry_cnt <= '0;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (!fifo_busy) begin
                        fifo_do_write <= op_write;
                        fifo_do_read  <= ~op_write;
                        fifo_di       <= wdata;
                        state         <= StCheck;
                    end
                end
                StCheck: begin
                    // First CHECK cycle carries the strobe; the ack is judged one cycle later.
                    if (fifo_do_write || fifo_do_read) begin
                        state <= StCheck;
                    end else if (ack) begin
                        lat_cnt <= '0;
                        if (op_write) begin
                            a_done <= (owner == OWN_A);
                            b_done <= (owner == OWN_B);
                            state  <= StDone;
                        end else begin
                            state <= StLat;
                        end
                    end else if (retry_cnt != LAST_TRY) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        state     <= StRecover;
                    end else begin
                        a_done <= (owner == OWN_A);
                        a_err  <= (owner == OWN_A);
                        b_done <= (owner == OWN_B);
                        b_err  <= (owner == OWN_B);
                        state  <= StDone;
                    end
                end
                StRecover: state <= StIssue;
                StLat: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (owner == OWN_A) begin
                            a_rdata <= fifo_do;
                            a_done  <= 1'b1;
                        end else begin
                            b_rdata <= fifo_do;
                            b_done  <= 1'b1;
                        end
                        state <= StDone;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                StDone: begin
                    rr_last <= owner;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a 4-entry FIFO model (registered ack, one-cycle bram).
module tb_fifo_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_write = 1'b0;
    logic [7:0] a_wdata = 8'h00;
    logic       a_done, a_err;
    logic [7:0] a_rdata;
    logic       b_req = 1'b0, b_write = 1'b0;
    logic [7:0] b_wdata = 8'h00;
    logic       b_done, b_err;
    logic [7:0] b_rdata;
    logic       fifo_do_read, fifo_do_write;
    logic [7:0] fifo_di;
    logic [7:0] fifo_do = 8'h00;
    logic       fifo_write_ack = 1'b0, fifo_read_ack = 1'b0;
    logic       fifo_busy = 1'b0;
    logic       fifo_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    fifo_arbiter #(.MAX_RETRY(4), .READ_LAT(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .a_req          (a_req),
        .a_write        (a_write),
        .a_wdata        (a_wdata),
        .a_done         (a_done),
        .a_err          (a_err),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_write        (b_write),
        .b_wdata        (b_wdata),
        .b_done         (b_done),
        .b_err          (b_err),
        .b_rdata        (b_rdata),
        .fifo_do_read   (fifo_do_read),
        .fifo_do_write  (fifo_do_write),
        .fifo_di        (fifo_di),
        .fifo_do        (fifo_do),
        .fifo_write_ack (fifo_write_ack),
        .fifo_read_ack  (fifo_read_ack),
        .fifo_busy      (fifo_busy)
    );

    always #5 clock = ~clock;

    // FIFO model: strobe sampled on an edge, ack for the following cycle, data one edge later.
    logic [7:0] mem [4];
    logic [1:0] wp = 2'd0, rp = 2'd0, raddr = 2'd0;
    int         cnt = 0;
    logic [7:0] wr_log [$];

    always @(posedge clock) begin
        fifo_write_ack <= 1'b0;
        fifo_read_ack  <= 1'b0;
        if (fifo_clr) begin
            wp  <= 2'd0;
            rp  <= 2'd0;
            cnt <= 0;
        end else if (fifo_do_write && cnt < 4) begin
            mem[wp]        <= fifo_di;
            wp             <= wp + 2'd1;
            cnt            <= cnt + 1;
            fifo_write_ack <= 1'b1;
            wr_log.push_back(fifo_di);
        end else if (fifo_do_read && cnt > 0) begin
            raddr         <= rp;
            rp            <= rp + 2'd1;
            cnt           <= cnt - 1;
            fifo_read_ack <= 1'b1;
        end
        fifo_do <= mem[raddr];
    end

    int rd_pulses = 0, wr_pulses = 0, a_done_cnt = 0, b_done_cnt = 0;
    int both_err = 0, gap_err = 0, rd_low = 0, wr_low = 0;

    always @(negedge clock) begin
        if (fifo_do_read && fifo_do_write) both_err++;
        if (fifo_do_read) begin
            rd_pulses++;
            if (rd_low < 2) gap_err++;
            rd_low = 0;
        end else rd_low++;
        if (fifo_do_write) begin
            wr_pulses++;
            if (wr_low < 2) gap_err++;
            wr_low = 0;
        end else wr_low++;
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    task automatic clear_fifo();
        @(posedge clock); #1;
        fifo_clr = 1'b1;
        @(posedge clock); #1;
        fifo_clr = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Drives one transaction on a port; lat = edges from the req-sampling window to done.
    task automatic run_txn(input bit port_b, input bit wr, input logic [7:0] data,
                           output int lat, output bit err, output logic [7:0] rd);
        @(posedge clock); #1;
        if (port_b) begin b_req = 1'b1; b_write = wr; b_wdata = data; end
        else        begin a_req = 1'b1; a_write = wr; a_wdata = data; end
        lat = -1; err = 1'b0; rd = 8'h00;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock); #1;
            if (port_b ? b_done : a_done) begin
                lat = i;
                err = port_b ? b_err : a_err;
                rd  = port_b ? b_rdata : a_rdata;
                break;
            end
        end
        @(posedge clock); #1;
        if (port_b) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({a_done, a_err, a_rdata, b_done, b_err, b_rdata, fifo_do_read, fifo_do_write,
             fifo_di} !== 29'd0) begin
            fails++;
            $display("FAIL reset_outputs: got a=%b/%b/%h b=%b/%b/%h rd=%b wr=%b di=%h want all 0",
                     a_done, a_err, a_rdata, b_done, b_err, b_rdata, fifo_do_read,
                     fifo_do_write, fifo_di);
        end
        reset = 1'b0;
        clear_fifo();
    endtask

    task automatic test_single_write();
        int lat; bit err; logic [7:0] rd;
        int w0 = wr_pulses, bd0 = b_done_cnt, l0 = wr_log.size();
        run_txn(1'b0, 1'b1, 8'h5A, lat, err, rd);
        tests++;
        if (lat !== 4 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_write_done: got lat=%0d err=%b want lat=4 err=0", lat, err);
        end
        tests++;
        if (wr_pulses - w0 !== 1) begin
            fails++;
            $display("FAIL single_write_pulses: got %0d want 1", wr_pulses - w0);
        end
        tests++;
        if (wr_log.size() !== l0 + 1 || wr_log[wr_log.size()-1] !== 8'h5A) begin
            fails++;
            $display("FAIL single_write_di: got size=%0d last=%h want size=%0d last=5a",
                     wr_log.size(), wr_log[wr_log.size()-1], l0 + 1);
        end
        tests++;
        if (b_done_cnt - bd0 !== 0) begin
            fails++;
            $display("FAIL single_write_b_idle: got %0d b_done pulses want 0", b_done_cnt - bd0);
        end
    endtask

    task automatic test_write_read();
        int lat; bit err; logic [7:0] rd;
        int r0, ad0;
        clear_fifo();
        run_txn(1'b0, 1'b1, 8'h3C, lat, err, rd);
        r0 = rd_pulses; ad0 = a_done_cnt;
        run_txn(1'b1, 1'b0, 8'h00, lat, err, rd);
        tests++;
        if (lat !== 5 || err !== 1'b0 || rd !== 8'h3C) begin
            fails++;
            $display("FAIL write_read: got lat=%0d err=%b rdata=%h want lat=5 err=0 rdata=3c",
                     lat, err, rd);
        end
        tests++;
        if (rd_pulses - r0 !== 1 || a_done_cnt - ad0 !== 0 || a_rdata !== 8'h00) begin
            fails++;
            $display("FAIL write_read_pulses: got rd=%0d a_done=%0d a_rdata=%h want 1 0 00",
                     rd_pulses - r0, a_done_cnt - ad0, a_rdata);
        end
    endtask

    task automatic test_empty_read();
        int lat; bit err; logic [7:0] rd;
        int r0 = rd_pulses, g0 = gap_err;
        run_txn(1'b1, 1'b0, 8'h00, lat, err, rd);
        tests++;
        if (lat < 0 || err !== 1'b1 || rd !== 8'h3C) begin
            fails++;
            $display("FAIL empty_read: got lat=%0d err=%b rdata=%h want done err=1 rdata=3c",
                     lat, err, rd);
        end
        tests++;
        if (rd_pulses - r0 !== 4 || gap_err - g0 !== 0) begin
            fails++;
            $display("FAIL empty_read_pulses: got %0d pulses %0d short gaps want 4 and 0",
                     rd_pulses - r0, gap_err - g0);
        end
    endtask

    task automatic test_contention();
        int a_idx = 0, b_idx = 0, l0;
        string order = "";
        apply_reset();
        clear_fifo();
        l0 = wr_log.size();
        @(posedge clock); #1;
        a_write = 1'b1; a_wdata = 8'h11; a_req = 1'b1;
        b_write = 1'b1; b_wdata = 8'h21; b_req = 1'b1;
        for (int i = 0; i < 80 && (a_idx < 2 || b_idx < 2); i++) begin
            @(posedge clock); #1;
            if (a_done) begin
                order = {order, "A"};
                a_idx++;
                if (a_idx == 2) a_req = 1'b0; else a_wdata = 8'h12;
            end
            if (b_done) begin
                order = {order, "B"};
                b_idx++;
                if (b_idx == 2) b_req = 1'b0; else b_wdata = 8'h22;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        tests++;
        if (order != "ABAB") begin
            fails++;
            $display("FAIL contention_order: got '%s' want 'ABAB'", order);
        end
        tests++;
        if (wr_log.size() !== l0 + 4 || wr_log[l0] !== 8'h11 || wr_log[l0+1] !== 8'h21 ||
            wr_log[l0+2] !== 8'h12 || wr_log[l0+3] !== 8'h22) begin
            fails++;
            $display("FAIL contention_writes: got %0d writes %h %h %h %h want 11 21 12 22",
                     wr_log.size() - l0, wr_log[l0], wr_log[l0+1], wr_log[l0+2], wr_log[l0+3]);
        end
    endtask

    task automatic test_full_write();
        int lat; bit err; logic [7:0] rd;
        int w0, fill_err = 0;
        clear_fifo();
        for (int i = 1; i <= 4; i++) begin
            run_txn(1'b0, 1'b1, 8'(i), lat, err, rd);
            if (lat != 4 || err) fill_err++;
        end
        tests++;
        if (fill_err !== 0) begin
            fails++;
            $display("FAIL full_fill: got %0d bad fill writes want 0", fill_err);
        end
        w0 = wr_pulses;
        run_txn(1'b0, 1'b1, 8'hEE, lat, err, rd);
        tests++;
        if (lat < 0 || err !== 1'b1 || wr_pulses - w0 !== 4) begin
            fails++;
            $display("FAIL full_write: got lat=%0d err=%b pulses=%0d want done err=1 pulses=4",
                     lat, err, wr_pulses - w0);
        end
        run_txn(1'b1, 1'b0, 8'h00, lat, err, rd);
        tests++;
        if (err !== 1'b0 || rd !== 8'h01) begin
            fails++;
            $display("FAIL full_readback: got err=%b rdata=%h want err=0 rdata=01", err, rd);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat; bit err; logic [7:0] rd;
        int r0, ad0;
        clear_fifo();
        run_txn(1'b1, 1'b1, 8'h77, lat, err, rd);
        run_txn(1'b1, 1'b1, 8'h88, lat, err, rd);
        r0 = rd_pulses; ad0 = a_done_cnt;
        @(posedge clock); #1;
        a_write = 1'b0; a_req = 1'b1;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1; a_req = 1'b0;
        @(posedge clock); #1;
        tests++;
        if ({a_done, a_err, a_rdata, b_done, b_err, b_rdata, fifo_do_read, fifo_do_write,
             fifo_di} !== 29'd0) begin
            fails++;
            $display("FAIL mid_read_reset: got a=%b/%b/%h b=%b/%b/%h di=%h want all 0",
                     a_done, a_err, a_rdata, b_done, b_err, b_rdata, fifo_di);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tests++;
        if (a_done_cnt - ad0 !== 0 || rd_pulses - r0 !== 1) begin
            fails++;
            $display("FAIL mid_read_no_done: got done=%0d rd=%0d want done=0 rd=1",
                     a_done_cnt - ad0, rd_pulses - r0);
        end
        run_txn(1'b0, 1'b0, 8'h00, lat, err, rd);
        tests++;
        if (lat !== 5 || err !== 1'b0 || rd !== 8'h88) begin
            fails++;
            $display("FAIL mid_read_reissue: got lat=%0d err=%b rdata=%h want 5 0 88",
                     lat, err, rd);
        end
    endtask

    task automatic test_busy();
        int w0, l0, ad0;
        bit seen = 1'b0;
        clear_fifo();
        w0 = wr_pulses; l0 = wr_log.size(); ad0 = a_done_cnt;
        @(posedge clock); #1;
        fifo_busy = 1'b1;
        a_write = 1'b1; a_wdata = 8'h42; a_req = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        tests++;
        if (wr_pulses - w0 !== 0 || a_done_cnt - ad0 !== 0) begin
            fails++;
            $display("FAIL busy_hold: got %0d strobes %0d dones want 0 0",
                     wr_pulses - w0, a_done_cnt - ad0);
        end
        fifo_busy = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock); #1;
            if (a_done) seen = 1'b1;
        end
        @(posedge clock); #1 a_req = 1'b0;
        tests++;
        if (!seen || wr_log.size() !== l0 + 1 || wr_log[wr_log.size()-1] !== 8'h42) begin
            fails++;
            $display("FAIL busy_release: got done=%b writes=%0d want done=1 one write of 42",
                     seen, wr_log.size() - l0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_read();
        test_empty_read();
        test_contention();
        test_full_write();
        test_reset_mid_read();
        test_busy();
        repeat (2) @(posedge clock);
        tests++;
        if (both_err !== 0 || gap_err !== 0) begin
            fails++;
            $display("FAIL strobe_rules: got %0d both-high %0d short gaps want 0 0",
                     both_err, gap_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Shares the single byte FIFO (bram-backed, do_read/do_write/ack/busy handshake) between two requesters: port A (1-wire bus engine) and port B (host/UART side).
- Accepts one byte transaction (read or write) per requester at a time.
- Drives the FIFO handshake with correctly timed single-cycle pulses and captures read data after the bram latency.
- Reports the result, or an error when the FIFO stays full or empty past a retry budget.

Parameters:
- MAX_RETRY, 4: attempts per transaction before reporting an error (1..15).
- READ_LAT, 1: cycles between the FIFO read_ack cycle and the cycle in which fifo_do is valid.

Ports:
- clock  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high
- a_req  in  1  requester A has a transaction pending; held until a_done
- a_write  in  1  1 = write, 0 = read; stable while a_req
- a_wdata  in  8  write byte; stable while a_req
- a_done  out  1  one-cycle completion pulse
- a_err  out  1  valid with a_done; 1 = retries exhausted (full on write, empty on read)
- a_rdata  out  8  read byte; valid with a_done on a successful read, held afterwards
- b_req, b_write, b_wdata, b_done, b_err, b_rdata: same as the A ports, for requester B
- fifo_do_read  out  1  to FIFO do_read
- fifo_do_write  out  1  to FIFO do_write
- fifo_di  out  8  to FIFO di
- fifo_do  in  8  from FIFO do
- fifo_write_ack  in  1  from FIFO
- fifo_read_ack  in  1  from FIFO
- fifo_busy  in  1  from FIFO

Behaviour:
- Reset values, all synchronous: every output 0, state IDLE, rr_last = B (so A wins first), retry count 0. Reset mid-transaction drops the transaction without any done pulse. The requester re-presents it after reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, CHECK, LAT, DONE, RECOVER.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the one not equal to rr_last.
  - Latch owner, write and wdata, clear retry count, go to ISSUE.
- ISSUE:
  - Wait while fifo_busy = 1.
  - When fifo_busy = 0, pulse fifo_do_write or fifo_do_read for exactly one cycle, with fifo_di = latched wdata. Go to CHECK.
  - The strobe must never be high for two consecutive cycles. The FIFO re-accepts a held strobe two cycles later, which would duplicate the transaction.
- CHECK (cycle after the strobe): the FIFO ack is deterministic here.
  - Matching ack = 1:
    - Write: go to DONE.
    - Read: go to LAT.
  - No ack, retry count + 1 < MAX_RETRY: increment retry count, go to RECOVER.
  - No ack, budget exhausted: set err, go to DONE.
- RECOVER: one idle cycle with the strobe low, then ISSUE. This gives one retry every 3 or more cycles.
- LAT: count READ_LAT cycles, then sample fifo_do into the owner's rdata register and go to DONE.
  - With READ_LAT = 1, the byte is sampled 2 cycles after the ack cycle. The FIFO registers addr with the ack, and the bram output registers one edge later.
- DONE:
  - Pulse owner_done for 1 cycle, with owner_err.
  - Update rr_last = owner.
  - Go to IDLE.
  - The requester drops or changes req in the cycle after done. A req still high in IDLE is treated as a new transaction.
- Latency with a non-busy FIFO and no retries:
  - Write: req to done = 4 cycles (IDLE, ISSUE, CHECK, DONE).
  - Read: 4 + READ_LAT cycles.
- Fairness and ownership:
  - Under continuous contention, grants strictly alternate A, B, A, ...
  - The non-owner's done, err and rdata are untouched during the other's transaction.
- A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
- The arbiter never drives do_read and do_write together.
- Wrap-around of the FIFO pointers is opaque here; only acks matter.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding constants (3-bit)
  - owner encoding OWN_A = 0, OWN_B = 1
  - retry counter width, 4 bits
- One natural sub-module: rr_arbiter2. It is a two-way round-robin picker: inputs req[1:0] and last; output grant index and grant_valid; purely combinational. The rest stays flat.

Test Plan:
1. Single write: after reset, A writes 0x5A with B idle. Expect fifo_do_write high for exactly 1 cycle, fifo_di = 0x5A, a_done 4 cycles after a_req with a_err = 0.
2. Write then read: A writes 0x3C, then B reads. Expect b_done with b_rdata = 0x3C at 4 + READ_LAT cycles, b_err = 0, and fifo_do_read pulsed exactly once.
3. Contention: A and B both request writes continuously (A: 0x11, 0x12; B: 0x21, 0x22) from reset. Expect FIFO write order 0x11, 0x21, 0x12, 0x22, with the done pulses alternating.
4. Empty read: B reads an empty FIFO with MAX_RETRY = 4. Expect exactly 4 single-cycle do_read pulses separated by at least 2 low cycles, then b_done = 1 with b_err = 1 and b_rdata unchanged.
5. Full write: fill the FIFO to capacity, then A writes 0xEE. Expect a_err = 1 after MAX_RETRY attempts. A read then returns the first byte written, not 0xEE.
6. Reset mid-read: assert reset in the LAT state. Expect all outputs 0 on the next cycle, no done pulse, and a re-issued read to complete normally.
